cmos_access_ctrl: RTL

Sequencer and arbiter in front of the CMOS/RTC register interface (PCF8583-style, 256-byte address space). It turns byte events from the I2C slave bit engine into word-pointer-addressed register reads and writes, with auto-increment. It also shares the same single-port register interface with a host (HPS) port used to load and save CMOS contents, and flags when I2C writes have modified battery-backed RAM.

---
 rtl/cmos_access_ctrl_if.sv | 46 ++++
 rtl/cmos_access_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cmos_access_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | cmos_access_ctrl_if
// | I2C byte events, host load/save port and register-interface signals.
// | Revision: 1.0
// +----------------------------------------------------------------------------
interface cmos_access_ctrl_if;
   logic       i2c_start;
   logic       i2c_wr_valid;
   logic [7:0] i2c_wr_data;
   logic       i2c_rd_req;
   logic [7:0] i2c_rd_data;
   logic       i2c_rd_valid;
   logic       host_req;
   logic       host_we;
   logic [7:0] host_addr;
   logic [7:0] host_wdata;
   logic       host_ack;
   logic [7:0] host_rdata;
   logic       host_clr_dirty;
   logic       dirty;
   logic [7:0] reg_addr;
   logic [7:0] reg_din;
   logic       reg_we;
   logic [7:0] reg_dout;

   // The access controller is the slave of both requesters.
   modport slave (
      input  i2c_start, i2c_wr_valid, i2c_wr_data, i2c_rd_req,
      output i2c_rd_data, i2c_rd_valid,
      input  host_req, host_we, host_addr, host_wdata, host_clr_dirty,
      output host_ack, host_rdata, dirty,
      output reg_addr, reg_din, reg_we,
      input  reg_dout
   );

   modport master (
      output i2c_start, i2c_wr_valid, i2c_wr_data, i2c_rd_req,
      input  i2c_rd_data, i2c_rd_valid,
      output host_req, host_we, host_addr, host_wdata, host_clr_dirty,
      input  host_ack, host_rdata, dirty,
      input  reg_addr, reg_din, reg_we,
      output reg_dout
   );
endinterface
`default_nettype wire

// File: rtl/cmos_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | cmos_access_ctrl
// | Word-pointer sequencer and I2C/host arbiter for the CMOS/RTC registers.
// | Optional macro CMOS_WP_EN drops I2C data writes to addresses 0x00-0x0F.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module cmos_access_ctrl (
   input  logic              clk,
   input  logic              rst,
   cmos_access_ctrl_if.slave bus
);
   localparam logic [7:0] c_NVRAM_BASE = 8'h10;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      I2C_WR    = 3'd1,
      I2C_RD_A  = 3'd2,
      I2C_RD_C  = 3'd3,
      HOST_WR   = 3'd4,
      HOST_RD_A = 3'd5,
      HOST_RD_C = 3'd6
   } state_t;

   state_t     r_state, w_state_next;
   logic [7:0] r_ptr, r_wr_data, r_rd_hold, r_host_hold;
   logic       r_ptr_phase, r_wr_pend, r_rd_pend, r_host_pend, r_dirty;
   logic       w_wr_grant, w_rd_grant, w_host_grant;
   logic       w_host_busy, w_data_wr, w_dirty_set, w_wp_hit;

`ifdef CMOS_WP_EN
   assign w_wp_hit = (r_ptr < c_NVRAM_BASE);
`else
   assign w_wp_hit = 1'b0;
`endif

   assign w_host_busy = (r_state == HOST_WR) || (r_state == HOST_RD_A) ||
                        (r_state == HOST_RD_C);
   assign w_data_wr   = (r_state == I2C_WR) && !r_ptr_phase;
   assign w_dirty_set = w_data_wr && (r_ptr >= c_NVRAM_BASE);
   assign bus.dirty   = r_dirty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= 8'h00;
         r_ptr_phase <= 1'b1;
         r_wr_pend   <= 1'b0;
         r_wr_data   <= 8'h00;
         r_rd_pend   <= 1'b0;
         r_host_pend <= 1'b0;
         r_rd_hold   <= 8'h00;
         r_host_hold <= 8'h00;
         r_dirty     <= 1'b0;
      end else begin
         r_state <= w_state_next;

         if (bus.i2c_wr_valid) begin
            r_wr_pend <= 1'b1;
            r_wr_data <= bus.i2c_wr_data;
         end else if (w_wr_grant) begin
            r_wr_pend <= 1'b0;
         end

         if (bus.i2c_rd_req)  r_rd_pend <= 1'b1;
         else if (w_rd_grant) r_rd_pend <= 1'b0;

         // Masking while granted/serviced lets host_req fall one cycle after ack.
         r_host_pend <= bus.host_req && !w_host_grant && !w_host_busy;

         if (bus.i2c_start)           r_ptr_phase <= 1'b1;
         else if (r_state == I2C_WR)  r_ptr_phase <= 1'b0;

         if (r_state == I2C_WR)         r_ptr <= r_ptr_phase ? r_wr_data : r_ptr + 8'd1;
         else if (r_state == I2C_RD_C)  r_ptr <= r_ptr + 8'd1;

         if (r_state == I2C_RD_C)  r_rd_hold   <= bus.reg_dout;
         if (r_state == HOST_RD_C) r_host_hold <= bus.reg_dout;

         if (w_dirty_set)             r_dirty <= 1'b1;
         else if (bus.host_clr_dirty) r_dirty <= 1'b0;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_wr_grant       = 1'b0;
      w_rd_grant       = 1'b0;
      w_host_grant     = 1'b0;
      bus.reg_we       = 1'b0;
      bus.reg_addr     = r_ptr;
      bus.reg_din      = r_wr_data;
      bus.i2c_rd_valid = 1'b0;
      bus.i2c_rd_data  = r_rd_hold;
      bus.host_ack     = 1'b0;
      bus.host_rdata   = r_host_hold;
      case (r_state)
         IDLE: begin
            if (r_wr_pend) begin
               w_wr_grant   = 1'b1;
               w_state_next = I2C_WR;
            end else if (r_rd_pend) begin
               w_rd_grant   = 1'b1;
               w_state_next = I2C_RD_A;
            end else if (r_host_pend) begin
               w_host_grant = 1'b1;
               w_state_next = bus.host_we ? HOST_WR : HOST_RD_A;
            end
         end
         I2C_WR: begin
            bus.reg_we   = w_data_wr && !w_wp_hit;
            w_state_next = IDLE;
         end
         I2C_RD_A: w_state_next = I2C_RD_C;
         I2C_RD_C: begin
            bus.i2c_rd_valid = 1'b1;
            bus.i2c_rd_data  = bus.reg_dout;
            w_state_next     = IDLE;
         end
         HOST_WR: begin
            bus.reg_addr = bus.host_addr;
            bus.reg_din  = bus.host_wdata;
            bus.reg_we   = 1'b1;
            bus.host_ack = 1'b1;
            w_state_next = IDLE;
         end
         HOST_RD_A: begin
            bus.reg_addr = bus.host_addr;
            w_state_next = HOST_RD_C;
         end
         HOST_RD_C: begin
            bus.reg_addr   = bus.host_addr;
            bus.host_ack   = 1'b1;
            bus.host_rdata = bus.reg_dout;
            w_state_next   = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end
endmodule
`default_nettype wire
